// File: rtl/arb_rr_hold_pkg.sv
// Shared definitions for the hold-capable arbiters: FSM state encoding,
// default sizing and a helper for the hold counter width.
package arb_rr_hold_pkg;

    // Arbiter handshake states shared by the arbiter family
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } arb_state_t;

    localparam int ARB_DEFAULT_N        = 8;
    localparam int ARB_DEFAULT_MAX_HOLD = 16;

    // Width needed to count 0..max_hold, never narrower than one bit
    function automatic int hold_width(input int max_hold);
        int w;
        w = $clog2(max_hold + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational circular picker: returns the first set bit of req found by
// searching upward from the one-hot start position and wrapping past the
// top. Implemented with the double-width mask-subtract trick so there is no
// priority chain proportional to N.
module arb_rr_pick #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] start,
    output logic [N-1:0] gnt
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] gnt_dbl;

    // Subtracting start clears the first request at or above start and leaves
    // lower bits untouched; the upper copy catches the wrapped-around case
    always_comb begin
        req_dbl = {req, req};
        gnt_dbl = req_dbl & ~(req_dbl - {{N{1'b0}}, start});
        gnt     = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];
    end

endmodule

// File: rtl/arb_rr_hold.sv
// N-way arbiter with fixed or round-robin priority in front of one shared
// downstream port. The grant is registered and held for a multi-cycle
// transfer; an optional hold cap force-releases transfers that run too long
// and flags that with a one-cycle preempt pulse.
module arb_rr_hold
    import arb_rr_hold_pkg::*;
#(
    parameter int  N        = ARB_DEFAULT_N,
    parameter int  MAX_HOLD = ARB_DEFAULT_MAX_HOLD,
    localparam int IDW      = (N > 1) ? $clog2(N) : 1,
    localparam int HW       = hold_width(MAX_HOLD)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_i,
    input  logic [N-1:0]   prio,
    input  logic           mode,
    output logic [N-1:0]   ack_i,
    output logic [IDW-1:0] grant_id_o,
    output logic           req_o,
    input  logic           ack_o,
    output logic           preempt_o
);

    localparam logic [N-1:0]  ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
    localparam logic [HW-1:0] CAP_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

    arb_state_t     state_q;
    arb_state_t     state_d;
    logic [N-1:0]   ptr_q;
    logic [HW-1:0]  cnt_q;
    logic [N-1:0]   prio_first;
    logic [N-1:0]   start_sel;
    logic [N-1:0]   winner;
    logic [IDW-1:0] winner_id;
    logic           hold_alive;
    logic           cap_hit;
    logic           release_now;

    // Fixed-mode start is the lowest set bit of prio, found by the same picker
    arb_rr_pick #(.N(N)) u_prio_pick (
        .req   (prio),
        .start (ONE_HOT0),
        .gnt   (prio_first)
    );

    // The actual winner among current requesters from the selected start
    arb_rr_pick #(.N(N)) u_req_pick (
        .req   (req_i),
        .start (start_sel),
        .gnt   (winner)
    );

    // Choose the search start and decide whether a running transfer ends now
    always_comb begin
        start_sel   = mode ? ptr_q : ((|prio) ? prio_first : ONE_HOT0);
        hold_alive  = |(req_i & ack_i);
        cap_hit     = (MAX_HOLD != 0) && (cnt_q == CAP_LAST);
        release_now = !hold_alive || cap_hit;
    end

    // One-hot to binary encode of the winner so the id is registered with ack_i
    always_comb begin
        winner_id = '0;
        for (int i = 0; i < N; i++) begin
            if (winner[i]) begin
                winner_id = IDW'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; req_o is a pure decode of the REQ state
    always_comb begin
        state_d = state_q;
        req_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                req_o = 1'b1;
                if (!(|req_i)) begin
                    state_d = ST_IDLE;
                end else if (ack_o) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (release_now) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant, hold counter, rotation pointer and preempt pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_i      <= '0;
            grant_id_o <= '0;
            cnt_q      <= '0;
            preempt_o  <= 1'b0;
            ptr_q      <= ONE_HOT0;
        end else begin
            preempt_o <= 1'b0;
            case (state_q)
                ST_REQ: begin
                    if ((|req_i) && ack_o) begin
                        ack_i      <= winner;
                        grant_id_o <= winner_id;
                        cnt_q      <= '0;
                    end
                end
                ST_BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (release_now) begin
                        ack_i     <= '0;
                        preempt_o <= hold_alive;
                        if (mode) begin
                            ptr_q <= {ack_i[N-2:0], ack_i[N-1]};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
